shift_sched: RTL and testbench

Two-requester scheduler for the shared 32-bit ARM barrel shifter. Arbitrates round-robin between two issue ports and keeps a per-requester carry (C) flag that feeds the shifter's carry input. Maps register-specified shift amounts (8-bit) onto the shifter's 5-bit immediate semantics and returns results through a one-entry registered response stage with valid/ready backpressure. Sits between the decode/issue stages of two execution contexts and the single shifter instance.

---
 rtl/shift_sched_pkg.sv | 14 +
 rtl/shift_sched_arb.sv | 30 +++
 rtl/shift_sched_shift.sv | 63 ++++++
 rtl/shift_sched.sv | 139 +++++++++++++
 tb/tb_shift_sched.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_sched_pkg.sv
// Shared constants and shift-op encodings for the barrel-shifter scheduler.
package shift_sched_pkg;

   localparam int DATA_WIDTH   = 32;
   localparam int AMOUNT_WIDTH = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {
      OP_LSL = 2'b00,
      OP_LSR = 2'b01,
      OP_ASR = 2'b10,
      OP_ROR = 2'b11
   } shift_op_e;

endpackage

// File: rtl/shift_sched_arb.sv
// Two-way round-robin arbiter; priority only rotates when a grant is actually accepted.
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   logic last_grant;

   always_comb begin
      grant = 2'b00;
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Reset to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant <= 1'b1;
      else if (accept)
         last_grant <= grant[1];
   end

endmodule

// File: rtl/shift_sched_shift.sv
// Combinational 32-bit ARM barrel shifter with immediate (amount 0..31) semantics.
module arm_shift_32
   import shift_sched_pkg::*;
(
   input  logic [DATA_WIDTH-1:0]   data,
   input  logic [AMOUNT_WIDTH-1:0] amount,
   input  shift_op_e               op,
   input  logic                    carry_in,
   output logic [DATA_WIDTH-1:0]   result,
   output logic                    carry_out
);

   logic [DATA_WIDTH:0]     lsl_w;
   logic [DATA_WIDTH:0]     lsr_w;
   logic [DATA_WIDTH:0]     asr_w;
   logic [2*DATA_WIDTH-1:0] ror_w;

   // The extra bit on each widened vector catches the last bit shifted out.
   always_comb begin
      lsl_w     = {1'b0, data} << amount;
      lsr_w     = {data, 1'b0} >> amount;
      asr_w     = $unsigned($signed({data, 1'b0}) >>> amount);
      ror_w     = {data, data} >> amount;
      result    = data;
      carry_out = carry_in;
      unique case (op)
         OP_LSL: begin
            if (amount != '0) begin
               result    = lsl_w[DATA_WIDTH-1:0];
               carry_out = lsl_w[DATA_WIDTH];
            end
         end
         OP_LSR: begin
            if (amount == '0) begin
               result    = '0;
               carry_out = data[DATA_WIDTH-1];
            end else begin
               result    = lsr_w[DATA_WIDTH:1];
               carry_out = lsr_w[0];
            end
         end
         OP_ASR: begin
            if (amount == '0) begin
               result    = {DATA_WIDTH{data[DATA_WIDTH-1]}};
               carry_out = data[DATA_WIDTH-1];
            end else begin
               result    = asr_w[DATA_WIDTH:1];
               carry_out = asr_w[0];
            end
         end
         OP_ROR: begin
            if (amount == '0) begin
               result    = {carry_in, data[DATA_WIDTH-1:1]};
               carry_out = data[0];
            end else begin
               result    = ror_w[DATA_WIDTH-1:0];
               carry_out = ror_w[DATA_WIDTH-1];
            end
         end
      endcase
   end

endmodule

// File: rtl/shift_sched.sv
// Schedules two requesters onto one barrel shifter, keeping per-requester C flags.
module shift_sched
   import shift_sched_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  r0_valid,
   output logic                  r0_ready,
   input  logic [1:0]            r0_op,
   input  logic                  r0_reg_shift,
   input  logic [7:0]            r0_amount,
   input  logic [DATA_WIDTH-1:0] r0_data,
   input  logic                  r0_set_c,
   input  logic                  r1_valid,
   output logic                  r1_ready,
   input  logic [1:0]            r1_op,
   input  logic                  r1_reg_shift,
   input  logic [7:0]            r1_amount,
   input  logic [DATA_WIDTH-1:0] r1_data,
   input  logic                  r1_set_c,
   input  logic [1:0]            c_load,
   input  logic [1:0]            c_load_val,
   output logic [1:0]            c_flag,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic                  resp_id,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  resp_carry
);

   logic [1:0]            grant;
   logic                  can_accept;
   logic                  accept;
   logic                  id;
   shift_op_e             sel_op;
   logic                  sel_reg;
   logic [7:0]            sel_amt;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_set_c;
   logic                  sel_c;
   logic [DATA_WIDTH-1:0] shift_result;
   logic                  shift_carry;
   logic [DATA_WIDTH-1:0] sh_result;
   logic                  sh_carry;

   assign can_accept = !resp_valid || resp_ready;
   assign r0_ready   = grant[0] & can_accept & rst_n;
   assign r1_ready   = grant[1] & can_accept & rst_n;
   assign accept     = r0_ready | r1_ready;
   assign id         = grant[1];

   rr_arbiter_2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    ({r1_valid, r0_valid}),
      .accept (accept),
      .grant  (grant)
   );

   assign sel_op    = shift_op_e'(id ? r1_op : r0_op);
   assign sel_reg   = id ? r1_reg_shift : r0_reg_shift;
   assign sel_amt   = id ? r1_amount : r0_amount;
   assign sel_data  = id ? r1_data : r0_data;
   assign sel_set_c = id ? r1_set_c : r0_set_c;
   assign sel_c     = c_flag[id];

   arm_shift_32 u_shift (
      .data      (sel_data),
      .amount    (sel_amt[AMOUNT_WIDTH-1:0]),
      .op        (sel_op),
      .carry_in  (sel_c),
      .result    (shift_result),
      .carry_out (shift_carry)
   );

   // Register-specified amounts of 0 or >=32 fall outside the shifter's immediate encoding.
   always_comb begin
      sh_result = shift_result;
      sh_carry  = shift_carry;
      if (sel_reg) begin
         if (sel_amt == 8'd0) begin
            sh_result = sel_data;
            sh_carry  = sel_c;
         end else if (sel_amt >= 8'd32) begin
            unique case (sel_op)
               OP_LSL: begin
                  sh_result = '0;
                  sh_carry  = (sel_amt == 8'd32) ? sel_data[0] : 1'b0;
               end
               OP_LSR: begin
                  sh_result = '0;
                  sh_carry  = (sel_amt == 8'd32) ? sel_data[DATA_WIDTH-1] : 1'b0;
               end
               OP_ASR: begin
                  sh_result = {DATA_WIDTH{sel_data[DATA_WIDTH-1]}};
                  sh_carry  = sel_data[DATA_WIDTH-1];
               end
               OP_ROR: begin
                  if (sel_amt[AMOUNT_WIDTH-1:0] == '0) begin
                     sh_result = sel_data;
                     sh_carry  = sel_data[DATA_WIDTH-1];
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_carry <= 1'b0;
         resp_id    <= 1'b0;
      end else if (accept) begin
         resp_valid <= 1'b1;
         resp_data  <= sh_result;
         resp_carry <= sh_carry;
         resp_id    <= id;
      end else if (resp_ready) begin
         resp_valid <= 1'b0;
      end
   end

   // An external c_load beats a shift-driven carry update on the same bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_flag <= 2'b00;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (c_load[i])
               c_flag[i] <= c_load_val[i];
            else if (accept && sel_set_c && (int'(id) == i))
               c_flag[i] <= sh_carry;
         end
      end
   end

endmodule

// File: tb/tb_shift_sched.sv
// Randomized self-checking bench for shift_sched against an ARM-semantics reference model.
module tb_shift_sched;
   import shift_sched_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        r0_valid, r1_valid;
   logic        r0_ready, r1_ready;
   logic [1:0]  r0_op, r1_op;
   logic        r0_reg_shift, r1_reg_shift;
   logic [7:0]  r0_amount, r1_amount;
   logic [31:0] r0_data, r1_data;
   logic        r0_set_c, r1_set_c;
   logic [1:0]  c_load, c_load_val;
   logic [1:0]  c_flag;
   logic        resp_valid, resp_ready;
   logic        resp_id;
   logic [31:0] resp_data;
   logic        resp_carry;

   int num_checks = 0;
   int num_fails  = 0;

   int          m_last;
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_carry;
   logic        m_id;
   logic [1:0]  m_flag;

   always #5 clk = ~clk;

   shift_sched dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .r0_valid     (r0_valid),
      .r0_ready     (r0_ready),
      .r0_op        (r0_op),
      .r0_reg_shift (r0_reg_shift),
      .r0_amount    (r0_amount),
      .r0_data      (r0_data),
      .r0_set_c     (r0_set_c),
      .r1_valid     (r1_valid),
      .r1_ready     (r1_ready),
      .r1_op        (r1_op),
      .r1_reg_shift (r1_reg_shift),
      .r1_amount    (r1_amount),
      .r1_data      (r1_data),
      .r1_set_c     (r1_set_c),
      .c_load       (c_load),
      .c_load_val   (c_load_val),
      .c_flag       (c_flag),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_id      (resp_id),
      .resp_data    (resp_data),
      .resp_carry   (resp_carry)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      num_checks++;
      if (observed !== expected) begin
         num_fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // ARM shifter semantics written from the architectural rules; returns {carry, result}.
   function automatic logic [32:0] ref_shift(input logic [1:0] op, input logic reg_shift,
                                             input logic [7:0] amount, input logic [31:0] d,
                                             input logic c);
      int          n;
      int          k;
      logic [31:0] r;
      logic        co;
      n = int'(amount);
      if (!reg_shift) begin
         n = n % 32;
         if (n == 0) begin
            case (op)
               2'd0:    return {c, d};
               2'd3:    return {d[0], c, d[31:1]};
               default: n = 32;
            endcase
         end
      end else if (n == 0) begin
         return {c, d};
      end
      case (op)
         2'd0: begin
            if (n < 32)       begin r = d << n; co = d[32-n]; end
            else if (n == 32) begin r = 0; co = d[0]; end
            else              begin r = 0; co = 1'b0; end
         end
         2'd1: begin
            if (n < 32)       begin r = d >> n; co = d[n-1]; end
            else if (n == 32) begin r = 0; co = d[31]; end
            else              begin r = 0; co = 1'b0; end
         end
         2'd2: begin
            if (n >= 32) begin r = {32{d[31]}}; co = d[31]; end
            else         begin r = $unsigned($signed(d) >>> n); co = d[n-1]; end
         end
         default: begin
            k = n % 32;
            if (k == 0) begin r = d; co = d[31]; end
            else        begin r = (d >> k) | (d << (32 - k)); co = r[31]; end
         end
      endcase
      return {co, r};
   endfunction

   task automatic model_reset();
      m_last  = 1;
      m_valid = 1'b0;
      m_data  = '0;
      m_carry = 1'b0;
      m_id    = 1'b0;
      m_flag  = 2'b00;
   endtask

   task automatic idle_inputs();
      r0_valid = 0; r1_valid = 0; r0_op = 0; r1_op = 0;
      r0_reg_shift = 0; r1_reg_shift = 0; r0_amount = 0; r1_amount = 0;
      r0_data = 0; r1_data = 0; r0_set_c = 0; r1_set_c = 0;
      c_load = 0; c_load_val = 0; resp_ready = 1;
   endtask

   // Called at a negedge with inputs already set; checks readies, clocks once, checks state.
   task automatic applyStimulus();
      int          gid;
      logic        can, e0, e1;
      logic [32:0] res;
      if (r0_valid && !r1_valid)      gid = 0;
      else if (r1_valid && !r0_valid) gid = 1;
      else                            gid = (m_last == 1) ? 0 : 1;
      can = !m_valid || resp_ready;
      e0  = r0_valid && gid == 0 && can;
      e1  = r1_valid && gid == 1 && can;
      #1;
      checkOutput("r0_ready", r0_ready, e0);
      checkOutput("r1_ready", r1_ready, e1);
      if (e0 || e1) begin
         if (gid == 0) res = ref_shift(r0_op, r0_reg_shift, r0_amount, r0_data, m_flag[0]);
         else          res = ref_shift(r1_op, r1_reg_shift, r1_amount, r1_data, m_flag[1]);
         m_valid = 1'b1;
         m_data  = res[31:0];
         m_carry = res[32];
         m_id    = (gid == 1);
         if ((gid == 0 && r0_set_c) || (gid == 1 && r1_set_c)) m_flag[gid] = res[32];
         m_last = gid;
      end else if (resp_ready) begin
         m_valid = 1'b0;
      end
      for (int i = 0; i < 2; i++)
         if (c_load[i]) m_flag[i] = c_load_val[i];
      @(posedge clk);
      #1;
      checkOutput("resp_valid", resp_valid, m_valid);
      checkOutput("resp_data", resp_data, m_data);
      checkOutput("resp_carry", resp_carry, m_carry);
      checkOutput("resp_id", resp_id, m_id);
      checkOutput("c_flag", c_flag, m_flag);
      @(negedge clk);
   endtask

   function automatic logic [7:0] pick_amount();
      case ($urandom_range(0, 7))
         0:       return 8'd0;
         1:       return 8'd1;
         2:       return 8'd31;
         3:       return 8'd32;
         4:       return 8'd33;
         5:       return 8'd64;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   task automatic random_inputs();
      r0_valid = ($urandom_range(0, 3) != 0);
      r1_valid = ($urandom_range(0, 3) != 0);
      r0_op = 2'($urandom); r1_op = 2'($urandom);
      r0_reg_shift = 1'($urandom); r1_reg_shift = 1'($urandom);
      r0_amount = pick_amount(); r1_amount = pick_amount();
      r0_data = $urandom; r1_data = $urandom;
      r0_set_c = 1'($urandom); r1_set_c = 1'($urandom);
      c_load = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      c_load_val = 2'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic reg_shift_r0(input logic [1:0] op, input logic [7:0] amt,
                               input logic [31:0] exp_data, input logic exp_carry);
      idle_inputs();
      r0_valid = 1; r0_op = op; r0_reg_shift = 1; r0_amount = amt; r0_data = 32'h8000_0001;
      applyStimulus();
      checkOutput("tp_reg_data", resp_data, exp_data);
      checkOutput("tp_reg_carry", resp_carry, exp_carry);
   endtask

   initial begin
      idle_inputs();
      model_reset();
      rst_n = 0;
      repeat (2) @(negedge clk);
      r0_valid = 1;
      #1;
      checkOutput("rst_ready", r0_ready, 1'b0);
      checkOutput("rst_valid", resp_valid, 1'b0);
      checkOutput("rst_data", resp_data, 32'h0);
      checkOutput("rst_cflag", c_flag, 2'b00);
      @(negedge clk);
      idle_inputs();
      rst_n = 1;
      @(negedge clk);

      // r0 LSL #4 of 0x80000001 with set_c
      r0_valid = 1; r0_op = 2'd0; r0_amount = 8'd4; r0_data = 32'h8000_0001; r0_set_c = 1;
      applyStimulus();
      checkOutput("tp_lsl4_data", resp_data, 32'h0000_0010);
      checkOutput("tp_lsl4_id", resp_id, 1'b0);
      checkOutput("tp_lsl4_c", c_flag[0], 1'b0);

      idle_inputs();
      c_load = 2'b10; c_load_val = 2'b10;
      applyStimulus();
      idle_inputs();
      r1_valid = 1; r1_op = 2'd3; r1_amount = 8'd0; r1_data = 32'h0000_0003;
      applyStimulus();
      checkOutput("tp_rrx_data", resp_data, 32'h8000_0001);
      checkOutput("tp_rrx_carry", resp_carry, 1'b1);

      reg_shift_r0(2'd0, 8'd32, 32'h0, 1'b1);
      reg_shift_r0(2'd1, 8'd33, 32'h0, 1'b0);
      reg_shift_r0(2'd2, 8'd200, 32'hFFFF_FFFF, 1'b1);
      reg_shift_r0(2'd3, 8'd64, 32'h8000_0001, 1'b1);
      reg_shift_r0(2'd1, 8'd0, 32'h8000_0001, 1'b0);

      // Both valid with resp_ready high: grants must alternate
      idle_inputs();
      r0_valid = 1; r1_valid = 1; r0_data = 32'h1; r1_data = 32'h2;
      for (int i = 0; i < 4; i++) applyStimulus();
      resp_ready = 0;
      for (int i = 0; i < 3; i++) applyStimulus();
      resp_ready = 1;
      for (int i = 0; i < 3; i++) applyStimulus();

      // c_load beats set_c, then the flag set by a shift feeds the next RRX
      idle_inputs();
      r0_valid = 1; r0_op = 2'd0; r0_amount = 8'd1; r0_data = 32'h8000_0000; r0_set_c = 1;
      c_load = 2'b01; c_load_val = 2'b00;
      applyStimulus();
      checkOutput("tp_prio_c", c_flag[0], 1'b0);
      c_load = 2'b00;
      applyStimulus();
      r0_op = 2'd3; r0_amount = 8'd0; r0_data = 32'h0; r0_set_c = 0;
      applyStimulus();
      checkOutput("tp_fresh_c", resp_data, 32'h8000_0000);

      for (int i = 0; i < 300; i++) begin
         random_inputs();
         applyStimulus();
      end

      // Mid-operation reset drops the pending response and clears flags at once
      random_inputs();
      r0_valid = 1;
      rst_n = 0;
      #1;
      checkOutput("midrst_valid", resp_valid, 1'b0);
      checkOutput("midrst_cflag", c_flag, 2'b00);
      checkOutput("midrst_ready", r0_ready, 1'b0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      idle_inputs();
      @(negedge clk);

      for (int i = 0; i < 300; i++) begin
         random_inputs();
         applyStimulus();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule
